// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size and state encodings for the dmem_rmw load/store front-end.
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_R = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_e;

endpackage

// File: rtl/dmem_align.sv
// dmem_align: combinational lane logic. Extracts and extends a load lane,
// and merges a store lane into an existing RAM word.
module dmem_align
    import dmem_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  shift;
    logic [31:0] lane;

    assign shift = {offset, 3'b000};
    assign lane  = word >> shift;

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        load_data = lane;
        merged    = wdata;
        case (size)
            SIZE_B: begin
                load_data = {{24{!is_unsigned && lane[7]}}, lane[7:0]};
                merged    = (word & ~(32'h0000_00FF << shift)) | ({24'b0, wdata[7:0]} << shift);
            end
            SIZE_H: begin
                load_data = {{16{!is_unsigned && lane[15]}}, lane[15:0]};
                merged    = (word & ~(32'h0000_FFFF << shift)) | ({16'b0, wdata[15:0]} << shift);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_rmw.sv
// dmem_rmw: RISC-V load/store front-end for a 32-bit RAM without byte enables.
// Sub-word stores run as read-modify-write; define DMEM_RMW_MISALIGN_EN to reject misaligned requests.
module dmem_rmw
    import dmem_pkg::*;
#(
    parameter int SCALE = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             ram_oe,
    output logic [SCALE-1:0] ram_addr,
    output logic [31:0]      ram_wdata,
    output logic             ram_we,
    input  logic [31:0]      ram_rdata
);

    state_e           state, state_next;
    size_e            size_eff;
    logic [1:0]       off_eff;
    logic             req_err, is_sub, accept, ram_we_raw;

    logic [SCALE-1:0] addr_q;
    logic [1:0]       off_q;
    size_e            size_q;
    logic [31:0]      wdata_q;

    logic             rsp_valid_q, rsp_we_q, rsp_uns_q, rsp_err_q;
    size_e            rsp_size_q;
    logic [1:0]       rsp_off_q;

    logic [31:0]      merged, load_data;
    logic [31:0]      unused_merge_load, unused_load_merge;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:SCALE+2];

    always_comb begin
        size_eff = size_e'(req_size);
        off_eff  = 2'b00;
`ifdef DMEM_RMW_MISALIGN_EN
        req_err = (req_size == SIZE_R)
               || (req_size == SIZE_H && req_addr[0])
               || (req_size == SIZE_W && req_addr[1:0] != 2'b00);
`else
        req_err = 1'b0;
        if (req_size == SIZE_R) size_eff = SIZE_W;
`endif
        // Offset bits below the access size are dropped, aligning the access down.
        case (size_eff)
            SIZE_B:  off_eff = req_addr[1:0];
            SIZE_H:  off_eff = {req_addr[1], 1'b0};
            default: off_eff = 2'b00;
        endcase
    end

    assign is_sub    = req_we && !req_err && (size_eff != SIZE_W);
    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_next = state;
        ram_oe     = 1'b0;
        ram_we_raw = 1'b0;
        ram_addr   = req_addr[SCALE+1:2];
        ram_wdata  = req_wdata;
        case (state)
            ST_IDLE: begin
                ram_oe     = req_valid && !req_err;
                ram_we_raw = req_valid && !req_err && req_we && !is_sub;
                if (req_valid && is_sub) state_next = ST_MERGE;
            end
            ST_MERGE: begin
                ram_oe     = 1'b1;
                ram_we_raw = 1'b1;
                ram_addr   = addr_q;
                ram_wdata  = merged;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Gating with rst keeps a reset-interrupted merge from writing a half-built word.
    assign ram_we = ram_we_raw && !rst;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state       <= state_next;
            rsp_valid_q <= (accept && !is_sub) || (state == ST_MERGE);
            if (accept) rsp_err_q <= req_err;
        end
    end

    // NOTE: pure datapath registers are not reset; they are always written before being used.
    always_ff @(posedge clk) begin
        if (accept) begin
            rsp_we_q   <= req_we;
            rsp_size_q <= size_eff;
            rsp_off_q  <= off_eff;
            rsp_uns_q  <= req_unsigned;
        end
        if (accept && is_sub) begin
            addr_q  <= req_addr[SCALE+1:2];
            off_q   <= off_eff;
            size_q  <= size_eff;
            wdata_q <= req_wdata;
        end
    end

    dmem_align u_merge (
        .size        (size_q),
        .offset      (off_q),
        .is_unsigned (1'b0),
        .word        (ram_rdata),
        .wdata       (wdata_q),
        .load_data   (unused_merge_load),
        .merged      (merged)
    );

    dmem_align u_load (
        .size        (rsp_size_q),
        .offset      (rsp_off_q),
        .is_unsigned (rsp_uns_q),
        .word        (ram_rdata),
        .wdata       (32'b0),
        .load_data   (load_data),
        .merged      (unused_load_merge)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_valid_q && rsp_err_q;
    assign rsp_rdata = (rsp_valid_q && !rsp_we_q && !rsp_err_q) ? load_data : 32'b0;

endmodule

// File: tb/tb_dmem_rmw.sv
// tb_dmem_rmw: directed plus random stimulus against a byte-array reference model
// of RISC-V loads/stores; a behavioural RAM with 1-cycle registered read is attached.
module tb_dmem_rmw;

    localparam int SCALE = 10;
    localparam int WORDS = 1 << SCALE;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready, req_we, req_unsigned;
    logic [31:0]      req_addr, req_wdata;
    logic [1:0]       req_size;
    logic             rsp_valid, rsp_err;
    logic [31:0]      rsp_rdata;
    logic             ram_oe, ram_we;
    logic [SCALE-1:0] ram_addr;
    logic [31:0]      ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    dmem_rmw #(.SCALE(SCALE)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_oe       (ram_oe),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_we       (ram_we),
        .ram_rdata    (ram_rdata)
    );

    logic [31:0] ram [WORDS];
    always @(posedge clk) begin
        if (ram_oe) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            ram_rdata <= ram[ram_addr];
        end
    end

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t       exp_q[$];
    logic [7:0] ref_mem [WORDS*4];
    int         cyc = 0;
    int         ready_block = -1;
    int         total = 0;
    int         bad = 0;
    bit         mon_on = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        if (size == 2'b00) return 1;
        if (size == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic ref_err(input logic [31:0] addr, input logic [1:0] size);
`ifdef DMEM_RMW_MISALIGN_EN
        return (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int base_of(input logic [31:0] addr, input logic [1:0] size);
        return int'(addr[SCALE+1:0]) & ~(nbytes(size) - 1);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        int          n = nbytes(size);
        int          b = base_of(addr, size);
        logic [31:0] v = 32'b0;
        for (int i = 0; i < n; i++) v |= 32'(ref_mem[b + i]) << (8 * i);
        if (n < 4 && !uns && v[8 * n - 1]) v |= 32'hFFFF_FFFF << (8 * n);
        return v;
    endfunction

    task automatic monitor();
        rsp_t e;
        check("req_ready", req_ready, (cyc == ready_block) ? 32'd0 : 32'd1);
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            check("rsp_valid", rsp_valid, 1);
            check("rsp_rdata", rsp_rdata, e.data);
            check("rsp_err", rsp_err, e.err);
        end else begin
            check("rsp_valid_idle", rsp_valid, 0);
            check("rsp_rdata_idle", rsp_rdata, 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mon_on) monitor();
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata);
        rsp_t e;
        logic err;
        int   n, b;
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        if (cyc == ready_block) tick();
        err = ref_err(addr, size);
        n   = nbytes(size);
        b   = base_of(addr, size);
        #1;
        check("ram_oe", ram_oe, !err);
        check("ram_we", ram_we, we && !err && n == 4);
        e.err  = err;
        e.data = 32'b0;
        e.due  = cyc + 1;
        if (!err) begin
            if (!we) begin
                e.data = ref_load(addr, size, uns);
            end else begin
                for (int i = 0; i < n; i++) ref_mem[b + i] = 8'(wdata >> (8 * i));
                if (n < 4) begin
                    e.due       = cyc + 2;
                    ready_block = cyc + 1;
                end
            end
        end
        exp_q.push_back(e);
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < WORDS * 4; i++) ref_mem[i] = 8'h00;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_size = 2'b00; req_unsigned = 1'b0; req_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_req_ready", req_ready, 1);
        mon_on = 1'b1;

        for (int i = 0; i < 32; i++) send(1'b1, 32'(i * 4), 2'b10, 1'b0, $urandom);

        send(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF);
        send(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
        idle(2);
        check("sw_ram", ram[4], 32'hDEAD_BEEF);

        send(1'b1, 32'h10, 2'b10, 1'b0, 32'h1122_3344);
        send(1'b1, 32'h13, 2'b00, 1'b0, 32'h0000_005A);
        idle(2);
        check("sb_ram", ram[4], 32'h5A22_3344);

        send(1'b1, 32'h10, 2'b10, 1'b0, 32'h8000_0000);
        send(1'b0, 32'h13, 2'b00, 1'b0, 32'h0);
        send(1'b0, 32'h13, 2'b00, 1'b1, 32'h0);
        send(1'b0, 32'h12, 2'b01, 1'b0, 32'h0);

        send(1'b1, 32'h20, 2'b10, 1'b0, 32'h1234_5678);
        send(1'b1, 32'h22, 2'b01, 1'b0, 32'h0000_BEEF);
        send(1'b0, 32'h20, 2'b10, 1'b0, 32'h0);
        idle(2);
        check("sh_ram", ram[8], 32'hBEEF_5678);

        send(1'b1, 32'h40, 2'b10, 1'b0, 32'h1122_3344);
        idle(3);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40;
        req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 32'hFF;
        @(negedge clk); cyc++;
        req_valid = 1'b0;
        rst = 1'b1;
        #1 check("merge_ready", req_ready, 0);
        @(negedge clk); cyc++;
        rst = 1'b0;
        #1;
        check("rst_merge_rsp_valid", rsp_valid, 0);
        check("rst_merge_ready", req_ready, 1);
        check("rst_merge_ram", ram[16], 32'h1122_3344);

        send(1'b0, 32'h22, 2'b10, 1'b0, 32'h0);
        send(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);

        for (int k = 0; k < 400; k++) begin
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
            send($urandom_range(0, 2) == 0, a, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(3);
        check("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
